// File: rtl/ram_access_ctrl.sv
// Front-end controller for a single-port synchronous RAM: arbitrates write and
// read requests, returns read data over a ready/valid response, and can zero the whole array.
module ram_access_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,

    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,

    input  logic                  clr_start,
    output logic                  busy,
    output logic                  clr_done,

    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = DEPTH[ADDR_WIDTH:0];

    typedef enum logic [2:0] {IDLE, WRITE, READ, CAPT, CLEAR} state_t;

    state_t                state;
    logic                  last_rd;
    // One bit wider than the address so the final count is reachable without wrapping.
    logic [ADDR_WIDTH:0]   clr_cnt;

    logic idle;
    logic rsp_free;
    logic wr_elig;
    logic rd_elig;
    logic wr_go;
    logic rd_go;

    always_comb begin
        idle     = (state == IDLE);
        rsp_free = !rsp_valid || rsp_ready;
        wr_elig  = idle && !clr_start;
        rd_elig  = wr_elig && rsp_free;
        // On a tie the side that did not win last time gets the grant.
        rd_ready = rd_elig && !(wr_valid && last_rd);
        wr_ready = wr_elig && !(rd_valid && rd_elig && !last_rd);
        rd_go    = rd_valid && rd_ready;
        wr_go    = wr_valid && wr_ready;
        busy     = !idle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_rd   <= 1'b0;
            clr_cnt   <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            clr_done  <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= '0;
                        ram_din  <= '0;
                        clr_cnt  <= {{ADDR_WIDTH{1'b0}}, 1'b1};
                    end else if (rd_go) begin
                        state    <= READ;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b0;
                        ram_addr <= rd_addr;
                        last_rd  <= 1'b1;
                    end else if (wr_go) begin
                        state    <= WRITE;
                        ram_en   <= 1'b1;
                        ram_we   <= 1'b1;
                        ram_addr <= wr_addr;
                        ram_din  <= wr_data;
                        last_rd  <= 1'b0;
                    end
                end
                WRITE: begin
                    ram_en <= 1'b0;
                    state  <= IDLE;
                end
                READ: begin
                    ram_en <= 1'b0;
                    state  <= CAPT;
                end
                CAPT: begin
                    // RAM output is only driven in this cycle; capture overrides any drain above.
                    rsp_data  <= ram_dout;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
                CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        ram_en   <= 1'b0;
                        clr_done <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        ram_addr <= clr_cnt[ADDR_WIDTH-1:0];
                        clr_cnt  <= clr_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural single-port RAM
// (registered read data, high-Z when not driven).
module tb_ram_access_ctrl;

    localparam int DW = 8;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_valid, rd_valid, rsp_ready, clr_start;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_ready, rsp_valid, busy, clr_done, ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, rsp_data;
    wire  [DW-1:0] ram_dout;

    ram_access_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .clr_start(clr_start), .busy(busy), .clr_done(clr_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout)
    );

    // RAM model
    logic [DW-1:0] mem [16];
    logic [DW-1:0] dout_q;
    logic          rd_q;
    logic          mem_fill;
    assign ram_dout = rd_q ? dout_q : 8'bz;

    always @(posedge clk) begin
        rd_q <= 1'b0;
        if (mem_fill) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else begin
                dout_q <= mem[ram_addr];
                rd_q   <= 1'b1;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    typedef struct {
        logic          is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs[9];

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        wr_addr = a; wr_data = d; wr_valid = 1'b1;
        #1 chk("wr_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("wr_en", ram_en, 1);
        chk("wr_we", ram_we, 1);
        chk("wr_addr", ram_addr, a);
        chk("wr_din", ram_din, d);
        chk("wr_busy", busy, 1);
        @(negedge clk);
        chk("wr_en_off", ram_en, 0);
        chk("wr_idle", busy, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        @(negedge clk);
        rd_addr = a; rd_valid = 1'b1; rsp_ready = 1'b1;
        #1 chk("rd_ready", rd_ready, 1);
        @(negedge clk);
        rd_valid = 1'b0;
        chk("rd_en", ram_en, 1);
        chk("rd_we", ram_we, 0);
        chk("rd_addr", ram_addr, a);
        chk("rd_early1", rsp_valid, 0);
        @(negedge clk);
        chk("rd_capt_en", ram_en, 0);
        chk("rd_capt_busy", busy, 1);
        chk("rd_early2", rsp_valid, 0);
        @(negedge clk);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_data", rsp_data, exp);
        chk("rd_idle", busy, 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        rsp_ready = 1'b1;
        while ((busy || rsp_valid) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("idle_timeout", {31'd0, busy | rsp_valid}, 0);
    endtask

    initial begin
        logic [3:0] g;
        int         ng;
        logic       prev_en;
        int         bad;
        int         pulses;
        int         busy_cnt;

        wr_valid = 0; rd_valid = 0; rsp_ready = 0; clr_start = 0;
        wr_addr = '0; rd_addr = '0; wr_data = '0;
        mem_fill = 1'b1;

        vecs[0] = '{1'b1, 4'h3, 8'hA5};
        vecs[1] = '{1'b0, 4'h3, 8'hA5};
        vecs[2] = '{1'b1, 4'h0, 8'h11};
        vecs[3] = '{1'b1, 4'hF, 8'h5A};
        vecs[4] = '{1'b0, 4'h0, 8'h11};
        vecs[5] = '{1'b0, 4'hF, 8'h5A};
        vecs[6] = '{1'b1, 4'h3, 8'h3C};
        vecs[7] = '{1'b0, 4'h3, 8'h3C};
        vecs[8] = '{1'b0, 4'h7, 8'hEE};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_en", ram_en, 0);
        chk("rst_we", ram_we, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_clr_done", clr_done, 0);
        chk("rst_busy", busy, 0);
        mem_fill = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].is_wr) do_write(vecs[i].addr, vecs[i].data);
            else               do_read(vecs[i].addr, vecs[i].data);
        end

        // round-robin with both requesters held high straight after reset
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'h1; wr_data = 8'h77;
        rd_valid = 1'b1; rd_addr = 4'h1; rsp_ready = 1'b1;
        g = '0; ng = 0; prev_en = 1'b0;
        for (int c = 0; c < 30 && ng < 4; c++) begin
            #1;
            if (rd_valid && rd_ready) begin g[ng] = 1'b1; ng++; end
            else if (wr_valid && wr_ready) begin g[ng] = 1'b0; ng++; end
            if (ram_en) chk("en_one_cycle", prev_en, 0);
            prev_en = ram_en;
            @(negedge clk);
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        chk("grant_count", ng, 4);
        chk("grant_order_RWRW", g, 4'b0101);
        wait_idle();

        // response back-pressure with a second read waiting
        @(negedge clk);
        rd_addr = 4'h3; rd_valid = 1'b1; rsp_ready = 1'b0;
        #1 chk("bp_rd_ready1", rd_ready, 1);
        @(negedge clk);
        rd_addr = 4'hF;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_data", rsp_data, 8'h3C);
            chk("bp_rd_ready_low", rd_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_rd_ready2", rd_ready, 1);
        @(negedge clk);
        rd_valid = 1'b0;
        chk("bp_rd2_en", ram_en, 1);
        chk("bp_rd2_addr", ram_addr, 4'hF);
        chk("bp_drained", rsp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        chk("bp_rd2_valid", rsp_valid, 1);
        chk("bp_rd2_data", rsp_data, 8'h5A);
        wait_idle();

        // full clear, read held pending through it, stray clr_start mid-clear
        @(negedge clk);
        clr_start = 1'b1; wr_valid = 1'b1; wr_addr = 4'h2; wr_data = 8'h99;
        #1 chk("clr_blocks_wr", wr_ready, 0);
        chk("clr_blocks_rd", rd_ready, 0);
        @(negedge clk);
        clr_start = 1'b0; wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 4'h3;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            clr_start = (i == 5);
            #1;
            if (!(busy && ram_en && ram_we && ram_addr == AW'(i) && ram_din == 8'h00
                  && !clr_done && !rd_ready)) bad++;
            @(negedge clk);
        end
        clr_start = 1'b0;
        chk("clear_seq_bad_cycles", bad, 0);
        #1;
        chk("clr_busy_off", busy, 0);
        chk("clr_done_pulse", clr_done, 1);
        chk("clr_en_off", ram_en, 0);
        chk("clr_rd_first_idle", rd_ready, 1);
        @(negedge clk);
        rd_valid = 1'b0;
        chk("clr_done_single", clr_done, 0);
        chk("post_clr_read_en", ram_en, 1);
        chk("post_clr_read_we", ram_we, 0);
        chk("post_clr_read_addr", ram_addr, 4'h3);
        @(negedge clk);
        @(negedge clk);
        chk("post_clr_rsp_valid", rsp_valid, 1);
        chk("post_clr_rsp_data", rsp_data, 8'h00);
        wait_idle();

        // reset during the seventh clear cycle
        @(negedge clk);
        clr_start = 1'b1;
        @(negedge clk);
        clr_start = 1'b0;
        repeat (6) @(negedge clk);
        chk("clr7_addr", ram_addr, 4'h6);
        rst_n = 1'b0;
        #1;
        chk("abort_en", ram_en, 0);
        chk("abort_we", ram_we, 0);
        chk("abort_addr", ram_addr, 0);
        chk("abort_din", ram_din, 0);
        chk("abort_busy", busy, 0);
        chk("abort_clr_done", clr_done, 0);
        chk("abort_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_valid = 1'b1; wr_addr = 4'h9; wr_data = 8'h42;
        #1 chk("abort_wr_ready", wr_ready, 1);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("abort_wr_we", ram_we, 1);
        chk("abort_wr_addr", ram_addr, 4'h9);
        pulses = 0; busy_cnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (clr_done) pulses++;
            if (busy) busy_cnt++;
        end
        chk("abort_no_clr_done", pulses, 0);
        chk("abort_no_resume", busy_cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requests
Module: ram_access_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of data words.
REQ-002 Parameter ADDR_WIDTH, default 8, width of addresses; depth is 2**ADDR_WIDTH.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset:
- clk, input, 1, the single clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous, active-low reset.
REQ-004 Write request port:
- wr_valid, input, 1, write request present.
- wr_ready, output, 1, write accepted on this edge when high together with wr_valid.
- wr_addr, input, ADDR_WIDTH, write address.
- wr_data, input, DATA_WIDTH, write data.
REQ-005 Read request port:
- rd_valid, input, 1, read request present.
- rd_ready, output, 1, read accepted on this edge when high together with rd_valid.
- rd_addr, input, ADDR_WIDTH, read address.
REQ-006 Read response port:
- rsp_valid, output, 1, rsp_data holds returned data.
- rsp_ready, input, 1, consumer takes the response.
- rsp_data, output, DATA_WIDTH, read data.
REQ-007 Clear control:
- clr_start, input, 1, request to zero the whole memory.
- busy, output, 1, controller is not in IDLE.
- clr_done, output, 1, one-cycle pulse when the clear finishes.
REQ-008 Downstream RAM port, connected to the single-port RAM:
- ram_en, output, 1, chip enable.
- ram_we, output, 1, write (1) or read (0).
- ram_addr, output, ADDR_WIDTH, RAM address.
- ram_din, output, DATA_WIDTH, RAM write data.
- ram_dout, input, DATA_WIDTH, RAM read data; valid only in the cycle after a read-enable cycle, otherwise high-Z.

Function
REQ-009 States SHALL be IDLE, WRITE, READ, CAPT and CLEAR.
REQ-010 ram_en, ram_we, ram_addr, ram_din, rsp_valid, rsp_data and clr_done SHALL be registered outputs.
REQ-011 wr_ready and rd_ready SHALL be combinational and high only in IDLE, with clr_start low and the arbitration below applied.
REQ-012 rd_ready SHALL also require rsp_valid low, or rsp_valid and rsp_ready both high in the same cycle.
REQ-013 Priority in IDLE SHALL be clr_start first, then read/write arbitration.
REQ-014 Arbitration: when both wr_valid and rd_valid are high and both are eligible, grant alternates round-robin.
- A last_rd flag, reset to 0, records the last grant.
- Write wins when last_rd is 1; read wins when last_rd is 0.
- On a tie right after reset, read wins.
REQ-015 Write accepted at edge E:
- In cycle E..E+1: state WRITE, ram_en=1, ram_we=1, ram_addr=wr_addr, ram_din=wr_data.
- Then return to IDLE.
- A write occupies 2 cycles.
REQ-016 Read accepted at edge E:
- In cycle E..E+1: state READ, ram_en=1, ram_we=0, ram_addr=rd_addr.
- In cycle E+1..E+2: state CAPT, ram_en=0.
- At edge E+2: rsp_data<=ram_dout, rsp_valid<=1, state returns to IDLE.
REQ-017 Read latency SHALL be exactly 2 cycles from the rd handshake edge to rsp_valid high.
REQ-018 In all non-access cycles ram_en SHALL be 0; ram_we, ram_addr and ram_din hold their last values.
REQ-019 Once high, rsp_valid SHALL stay high and rsp_data SHALL stay stable until an edge where rsp_ready is high; rsp_valid then clears unless a new capture occurs on that same edge.
REQ-020 clr_start in IDLE SHALL enter CLEAR.
- Writes 0 to addresses 0..2**ADDR_WIDTH-1, one per cycle, ascending: ram_en=1, ram_we=1, ram_din=0.
- Takes exactly 2**ADDR_WIDTH cycles.
- The clear counter is ADDR_WIDTH+1 bits so there is no wrap before termination.
- After the last address: clr_done pulses for 1 cycle and the state returns to IDLE.
REQ-021 clr_start outside IDLE SHALL be ignored and not queued.
REQ-022 wr_ready and rd_ready SHALL be 0 during CLEAR; a pending rsp_valid is still drained during CLEAR.
REQ-023 busy SHALL equal (state != IDLE).
REQ-024 Requests held through non-IDLE states SHALL be accepted no earlier than the first IDLE cycle.

Reset
REQ-025 While rst_n=0, all registers SHALL reset asynchronously:
- State IDLE, last_rd=0, clear counter 0.
- ram_en=0, ram_we=0, ram_addr=0, ram_din=0.
- rsp_valid=0, rsp_data=0, clr_done=0.
REQ-026 Reset mid-WRITE, READ, CAPT or CLEAR SHALL abort the operation: no response is produced, clr_done does not pulse, and a partial clear is not resumed.

Verification
REQ-027 Write 0xA5 to addr 3, then read addr 3 with rsp_ready=1 -> ram_en,we=1,1 for one cycle; rsp_valid rises exactly 2 cycles after the rd handshake with rsp_data=0xA5.
REQ-028 wr_valid and rd_valid held high continuously after reset -> grants alternate R,W,R,W; every ram_en pulse is 1 cycle.
REQ-029 Read with rsp_ready=0 for 5 cycles, second read pending -> rsp_data stable and rd_ready=0 throughout; second read is accepted on the edge rsp_ready=1 is sampled.
REQ-030 ADDR_WIDTH=4, clr_start pulse -> 16 consecutive zero writes to addrs 0..15, busy high 16 cycles, single clr_done pulse; subsequent read of addr 3 returns 0x00.
REQ-031 rst_n low during cycle 7 of CLEAR -> all outputs reset immediately; no clr_done; wr_ready high on the first cycle after release when wr_valid=1.
